// File: rtl/sseg_x4_scan_ctrl_pkg.sv
// Shared 7-segment definitions for the scan controller and the display monitor.
// Segment order is gfedcba, active LOW (a 0 lights the segment).
package sseg_pkg;

  localparam logic [6:0] SSEG_0   = 7'b1000000;
  localparam logic [6:0] SSEG_1   = 7'b1111001;
  localparam logic [6:0] SSEG_2   = 7'b0100100;
  localparam logic [6:0] SSEG_3   = 7'b0110000;
  localparam logic [6:0] SSEG_4   = 7'b0011001;
  localparam logic [6:0] SSEG_5   = 7'b0010010;
  localparam logic [6:0] SSEG_6   = 7'b0000010;
  localparam logic [6:0] SSEG_7   = 7'b1111000;
  localparam logic [6:0] SSEG_8   = 7'b0000000;
  localparam logic [6:0] SSEG_9   = 7'b0010000;
  localparam logic [6:0] SSEG_OFF = 7'b1111111;

  // All four anodes released (active LOW).
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Phase within one digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // BCD to segment pattern; non-decimal nibbles render dark.
  function automatic logic [6:0] bcd2sseg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SSEG_0;
      4'd1:    seg = SSEG_1;
      4'd2:    seg = SSEG_2;
      4'd3:    seg = SSEG_3;
      4'd4:    seg = SSEG_4;
      4'd5:    seg = SSEG_5;
      4'd6:    seg = SSEG_6;
      4'd7:    seg = SSEG_7;
      4'd8:    seg = SSEG_8;
      4'd9:    seg = SSEG_9;
      default: seg = SSEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_x4_scan_ctrl_decoder.sv
// Combinational BCD to 7-segment decoder built on the shared table.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure table lookup, no state.
  always_comb begin
    seg_o = bcd2sseg(bcd_i);
  end

endmodule

// File: rtl/sseg_x4_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scan controller.
// The digit value is snapshotted once per frame (on the last cycle of digit 3)
// so a frame never mixes old and new digits. Each slot starts with DEAD blank
// cycles to suppress ghosting, then drives one anode for DIV-DEAD cycles.
// All outputs are registered, so they lag the counter state by one cycle.
module sseg_x4_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIV  = 100000,
  parameter int DEAD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        lzb,
  output logic [6:0]  sseg_ca,
  output logic [3:0]  sseg_an,
  output logic        frame_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          snap_lzb_q, snap_lzb_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    ca_q, ca_d;
  logic          fd_q, fd_d;

  logic          slot_end;
  logic          frame_end;
  phase_e        phase;
  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic [3:0]    nib_zero;
  logic [3:0]    lz_blank;
  logic          digit_blank;

  // Slot and frame boundaries derived from the current counter state.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == 2'd3);
    phase     = (cnt_q < DEAD_CNT) ? PH_BLANK : PH_DRIVE;
  end

  // Counter wraps every slot; index advances on the wrap; snapshot loads at frame end.
  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
    snap_d     = frame_end ? digits : snap_q;
    snap_lzb_d = frame_end ? lzb : snap_lzb_q;
  end

  // Leading-zero blanking: a digit is blanked when it and every digit above are zero.
  // Digit 0 is never blanked so a zero value still shows a single 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nib_zero[i] = (snap_q[4*i +: 4] == 4'd0);
    end
    lz_blank[3] = snap_lzb_q & nib_zero[3];
    lz_blank[2] = lz_blank[3] & nib_zero[2];
    lz_blank[1] = lz_blank[2] & nib_zero[1];
    lz_blank[0] = 1'b0;
    digit_blank = lz_blank[idx_q];
    cur_nib     = snap_q[{idx_q, 2'b00} +: 4];
  end

  sseg_decoder u_decoder (
    .bcd_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Next output values: dark during the blank phase or for a blanked leading zero.
  always_comb begin
    an_d = ANODES_OFF;
    ca_d = SSEG_OFF;
    fd_d = frame_end;
    if (phase == PH_DRIVE && !digit_blank) begin
      an_d = ~(4'b0001 << idx_q);
      ca_d = dec_seg;
    end
  end

  // Scan state and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      snap_q     <= 16'h0000;
      snap_lzb_q <= 1'b0;
      an_q       <= ANODES_OFF;
      ca_q       <= SSEG_OFF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      snap_lzb_q <= snap_lzb_d;
      an_q       <= an_d;
      ca_q       <= ca_d;
      fd_q       <= fd_d;
    end
  end

  assign sseg_an    = an_q;
  assign sseg_ca    = ca_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_x4_scan_ctrl.sv
// Directed bench for the 4-digit scan controller with DIV=8, DEAD=2.
module tb_sseg_x4_scan_ctrl;

  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic        lzb;
  logic [6:0]  sseg_ca;
  logic [3:0]  sseg_an;
  logic        frame_done;

  int total;
  int bad;

  // Hand-written segment table (gfedcba, active LOW).
  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  logic [3:0] an_log [FRAME];
  logic [6:0] ca_log [FRAME];
  logic       fd_log [FRAME];
  logic [3:0] mon [4];

  sseg_x4_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .lzb        (lzb),
    .sseg_ca    (sseg_ca),
    .sseg_an    (sseg_an),
    .frame_done (frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- display monitor ----------------
  function automatic logic [3:0] seg2nib(input logic [6:0] s);
    logic [3:0] n;
    n = 4'hE;
    if (s == 7'b1111111) n = 4'hF;
    for (int i = 0; i < 10; i++) if (s == seg_tbl[i]) n = 4'(i);
    return n;
  endfunction

  initial for (int i = 0; i < 4; i++) mon[i] = 4'hF;

  always @(negedge clk) begin
    case (sseg_an)
      4'b1110: mon[0] = seg2nib(sseg_ca);
      4'b1101: mon[1] = seg2nib(sseg_ca);
      4'b1011: mon[2] = seg2nib(sseg_ca);
      4'b0111: mon[3] = seg2nib(sseg_ca);
      default: ;
    endcase
  end

  function automatic logic [15:0] mon_val();
    return {mon[3], mon[2], mon[1], mon[0]};
  endfunction

  // ---------------- expected-value model ----------------
  function automatic bit lz_blanked(input logic [15:0] d, input logic l, input int k);
    if (!l || k == 0) return 1'b0;
    for (int m = k; m < 4; m++) if (d[4*m +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_an(input logic [15:0] d, input logic l, input int j);
    int k;
    int c;
    k = j / DIV;
    c = j % DIV;
    if (c < DEAD || lz_blanked(d, l, k)) return 4'b1111;
    return ~(4'b0001 << k);
  endfunction

  function automatic logic [6:0] exp_ca(input logic [15:0] d, input logic l, input int j);
    int k;
    int c;
    logic [3:0] nib;
    k = j / DIV;
    c = j % DIV;
    nib = d[4*k +: 4];
    if (c < DEAD || lz_blanked(d, l, k)) return 7'b1111111;
    if (nib > 4'd9) return 7'b1111111;
    return seg_tbl[nib];
  endfunction

  // ---------------- driver tasks ----------------
  // Samples one full frame starting with slot 0, cnt 0. Optionally changes the
  // inputs right after sample chg_at (values applied at or before sample 30
  // are captured at the end of this frame).
  task automatic log_frame(input int chg_at, input logic [15:0] nd, input logic nl);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      an_log[j] = sseg_an;
      ca_log[j] = sseg_ca;
      fd_log[j] = frame_done;
      if (j == chg_at) begin
        digits = nd;
        lzb    = nl;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b1;
    digits = 16'h1234;
    lzb    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (sseg_an !== 4'b1111 || sseg_ca !== 7'b1111111 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d an=%b ca=%b fd=%b want an=1111 ca=1111111 fd=0",
                 i, sseg_an, sseg_ca, frame_done);
      end
    end
    rst = 1'b0;
    log_frame(-1, 16'h0, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h0000, 1'b0, j) || ca_log[j] !== exp_ca(16'h0000, 1'b0, j)
          || fd_log[j] !== (j == FRAME - 1)) begin
        bad++;
        $display("FAIL first_frame j=%0d an=%b ca=%b fd=%b want an=%b ca=%b fd=%b", j,
                 an_log[j], ca_log[j], fd_log[j], exp_an(16'h0000, 1'b0, j),
                 exp_ca(16'h0000, 1'b0, j), (j == FRAME - 1));
      end
    end
    total++;
    if (mon_val() !== 16'h0000) begin
      bad++;
      $display("FAIL first_frame_mon got=%h want=0000", mon_val());
    end
  endtask

  task automatic test_basic_scan();
    log_frame(-1, 16'h0, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h1234, 1'b0, j) || ca_log[j] !== exp_ca(16'h1234, 1'b0, j)
          || fd_log[j] !== (j == FRAME - 1)) begin
        bad++;
        $display("FAIL basic_scan j=%0d an=%b ca=%b fd=%b want an=%b ca=%b fd=%b", j,
                 an_log[j], ca_log[j], fd_log[j], exp_an(16'h1234, 1'b0, j),
                 exp_ca(16'h1234, 1'b0, j), (j == FRAME - 1));
      end
    end
    total++;
    if (mon_val() !== 16'h1234) begin
      bad++;
      $display("FAIL basic_scan_mon got=%h want=1234", mon_val());
    end
  endtask

  task automatic test_tearing();
    // Change while slot 1 is on screen; this frame must still be 1234.
    log_frame(10, 16'h5678, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h1234, 1'b0, j) || ca_log[j] !== exp_ca(16'h1234, 1'b0, j)) begin
        bad++;
        $display("FAIL tearing_old j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h1234, 1'b0, j), exp_ca(16'h1234, 1'b0, j));
      end
    end
    // Queue the leading-zero case for the following frame.
    log_frame(0, 16'h0050, 1'b1);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h5678, 1'b0, j) || ca_log[j] !== exp_ca(16'h5678, 1'b0, j)) begin
        bad++;
        $display("FAIL tearing_new j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h5678, 1'b0, j), exp_ca(16'h5678, 1'b0, j));
      end
    end
    total++;
    if (mon_val() !== 16'h5678) begin
      bad++;
      $display("FAIL tearing_mon got=%h want=5678", mon_val());
    end
  endtask

  task automatic test_lzb();
    log_frame(0, 16'h0000, 1'b1);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h0050, 1'b1, j) || ca_log[j] !== exp_ca(16'h0050, 1'b1, j)) begin
        bad++;
        $display("FAIL lzb_0050 j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h0050, 1'b1, j), exp_ca(16'h0050, 1'b1, j));
      end
      total++;
      if (an_log[j][3] !== 1'b1 || an_log[j][2] !== 1'b1) begin
        bad++;
        $display("FAIL lzb_upper_off j=%0d an=%b want an[3:2]=11", j, an_log[j]);
      end
    end
    // Zero with blanking: only anode 0, showing 0. Queue the illegal-nibble case.
    log_frame(3, 16'h12A4, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h0000, 1'b1, j) || ca_log[j] !== exp_ca(16'h0000, 1'b1, j)) begin
        bad++;
        $display("FAIL lzb_0000 j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h0000, 1'b1, j), exp_ca(16'h0000, 1'b1, j));
      end
    end
  endtask

  task automatic test_illegal_nibble();
    log_frame(5, 16'h9876, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h12A4, 1'b0, j) || ca_log[j] !== exp_ca(16'h12A4, 1'b0, j)) begin
        bad++;
        $display("FAIL illegal j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h12A4, 1'b0, j), exp_ca(16'h12A4, 1'b0, j));
      end
    end
    // Slot 1 drive phase: anode 1 low, segments dark.
    total++;
    if (an_log[DIV + DEAD] !== 4'b1101 || ca_log[DIV + DEAD] !== 7'b1111111) begin
      bad++;
      $display("FAIL illegal_slot1 an=%b ca=%b want an=1101 ca=1111111",
               an_log[DIV + DEAD], ca_log[DIV + DEAD]);
    end
  endtask

  task automatic test_mid_reset();
    // Advance into the drive phase of slot 2 (digit 8 of 9876).
    for (int j = 0; j < 2 * DIV + DEAD + 1; j++) @(negedge clk);
    total++;
    if (sseg_an !== 4'b1011 || sseg_ca !== seg_tbl[8]) begin
      bad++;
      $display("FAIL mid_pre an=%b ca=%b want an=1011 ca=%b", sseg_an, sseg_ca, seg_tbl[8]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (sseg_an !== 4'b1111 || sseg_ca !== 7'b1111111 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_async an=%b ca=%b fd=%b want an=1111 ca=1111111 fd=0",
               sseg_an, sseg_ca, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    log_frame(-1, 16'h0, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h0000, 1'b0, j) || ca_log[j] !== exp_ca(16'h0000, 1'b0, j)
          || fd_log[j] !== (j == FRAME - 1)) begin
        bad++;
        $display("FAIL mid_restart j=%0d an=%b ca=%b fd=%b want an=%b ca=%b fd=%b", j,
                 an_log[j], ca_log[j], fd_log[j], exp_an(16'h0000, 1'b0, j),
                 exp_ca(16'h0000, 1'b0, j), (j == FRAME - 1));
      end
    end
    log_frame(-1, 16'h0, 1'b0);
    for (int j = 0; j < FRAME; j++) begin
      total++;
      if (an_log[j] !== exp_an(16'h9876, 1'b0, j) || ca_log[j] !== exp_ca(16'h9876, 1'b0, j)) begin
        bad++;
        $display("FAIL mid_recapture j=%0d an=%b ca=%b want an=%b ca=%b", j, an_log[j],
                 ca_log[j], exp_an(16'h9876, 1'b0, j), exp_ca(16'h9876, 1'b0, j));
      end
    end
    total++;
    if (mon_val() !== 16'h9876) begin
      bad++;
      $display("FAIL mid_recapture_mon got=%h want=9876", mon_val());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    digits = 16'h0000;
    lzb    = 1'b0;
    test_reset();
    test_basic_scan();
    test_tearing();
    test_lzb();
    test_illegal_nibble();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
